// File: rtl/mem_io_bus.sv
// Bus controller between the multicycle CPU, a 1-cycle synchronous RAM and NUM_IO
// memory-mapped peripheral channels. Define IO_TIMEOUT_EN to bound every I/O wait.
module mem_io_bus #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int NUM_IO  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_adr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_ack,
    output logic                     busy,
    output logic                     bus_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_adr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NUM_IO-1:0]        io_req,
    output logic                     io_we,
    output logic [ADDR_W-3:0]        io_adr,
    output logic [DATA_W-1:0]        io_wdata,
    input  logic [NUM_IO*DATA_W-1:0] io_rdata,
    input  logic [NUM_IO-1:0]        io_ack
);

    typedef enum logic [2:0] {S_IDLE, S_MEM, S_MEM_WAIT, S_IO, S_RESP} state_t;

    localparam int SEL_W = $clog2(NUM_IO);
    localparam int CH_W  = (SEL_W > 0) ? SEL_W : 1;

    state_t              r_state, w_next_state;
    logic                r_we;
    logic [CH_W-1:0]     r_ch;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic                r_cpu_ack, r_busy;
    logic                r_mem_en, r_mem_we;
    logic [ADDR_W-1:0]   r_mem_adr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [NUM_IO-1:0]   r_io_req;
    logic                r_io_we;
    logic [ADDR_W-3:0]   r_io_adr;
    logic [DATA_W-1:0]   r_io_wdata;

    logic [ADDR_W-3:0]   w_offset;
    logic                w_is_io, w_mapped, w_ack, w_timeout;
    logic [CH_W-1:0]     w_ch;
    logic [NUM_IO-1:0]   w_onehot;
    logic [DATA_W-1:0]   w_rslice;

    logic                w_we_nxt;
    logic [CH_W-1:0]     w_ch_nxt;
    logic [DATA_W-1:0]   w_cpu_rdata_nxt;
    logic                w_mem_en_nxt, w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_adr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic [NUM_IO-1:0]   w_io_req_nxt;
    logic                w_io_we_nxt;
    logic [ADDR_W-3:0]   w_io_adr_nxt;
    logic [DATA_W-1:0]   w_io_wdata_nxt;

    // Top two address bits 2'b11 select I/O space; offset bits above the channel select must be 0.
    assign w_offset = cpu_adr[ADDR_W-3:0];
    assign w_is_io  = (cpu_adr[ADDR_W-1:ADDR_W-2] == 2'b11);
    assign w_mapped = ((w_offset >> SEL_W) == '0);
    assign w_ch     = w_offset[CH_W-1:0];
    assign w_ack    = io_ack[r_ch];
    assign w_rslice = io_rdata[r_ch*DATA_W +: DATA_W];

    always_comb begin
        w_onehot       = '0;
        w_onehot[w_ch] = 1'b1;
    end

`ifdef IO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;
    logic             w_bus_err_nxt;

    assign w_timeout     = (r_wait_cnt == CNT_W'(TIMEOUT));
    assign w_bus_err_nxt = (r_state == S_IO) && !w_ack && w_timeout;
    assign bus_err       = r_bus_err;

    // Counter idles at 0 outside IO, so it starts from 0 on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err  <= w_bus_err_nxt;
            r_wait_cnt <= (r_state == S_IO) ? r_wait_cnt + CNT_W'(1) : '0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // NOTE: synchronous reset clears every register; sequential state updates only with <=.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_ch        <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
            r_io_req    <= '0;
            r_io_we     <= 1'b0;
            r_io_adr    <= '0;
            r_io_wdata  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_we        <= w_we_nxt;
            r_ch        <= w_ch_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_cpu_ack   <= (w_next_state == S_RESP);
            r_busy      <= (w_next_state != S_IDLE);
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_adr   <= w_mem_adr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_io_req    <= w_io_req_nxt;
            r_io_we     <= w_io_we_nxt;
            r_io_adr    <= w_io_adr_nxt;
            r_io_wdata  <= w_io_wdata_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    if (!w_is_io)      w_next_state = S_MEM;
                    else if (w_mapped) w_next_state = S_IO;
                    else               w_next_state = S_RESP;
                end
            end
            S_MEM:      w_next_state = S_MEM_WAIT;
            S_MEM_WAIT: w_next_state = S_RESP;
            S_IO:       if (w_ack || w_timeout) w_next_state = S_RESP;
            S_RESP:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case, so no latch can be inferred.
    always_comb begin
        w_we_nxt        = r_we;
        w_ch_nxt        = r_ch;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_adr_nxt   = r_mem_adr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_io_req_nxt    = r_io_req;
        w_io_we_nxt     = r_io_we;
        w_io_adr_nxt    = r_io_adr;
        w_io_wdata_nxt  = r_io_wdata;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_we_nxt = cpu_we;
                    if (!w_is_io) begin
                        w_mem_en_nxt    = 1'b1;
                        w_mem_we_nxt    = cpu_we;
                        w_mem_adr_nxt   = cpu_adr;
                        w_mem_wdata_nxt = cpu_wdata;
                    end else if (w_mapped) begin
                        w_ch_nxt       = w_ch;
                        w_io_req_nxt   = w_onehot;
                        w_io_we_nxt    = cpu_we;
                        w_io_adr_nxt   = w_offset;
                        w_io_wdata_nxt = cpu_wdata;
                    end else begin
                        w_cpu_rdata_nxt = '0;
                    end
                end
            end
            S_MEM_WAIT: w_cpu_rdata_nxt = r_we ? '0 : mem_rdata;
            S_IO: begin
                if (w_ack) begin
                    w_cpu_rdata_nxt = r_we ? '0 : w_rslice;
                    w_io_req_nxt    = '0;
                    w_io_we_nxt     = 1'b0;
                end else if (w_timeout) begin
                    w_cpu_rdata_nxt = '1;
                    w_io_req_nxt    = '0;
                    w_io_we_nxt     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;
    assign io_req    = r_io_req;
    assign io_we     = r_io_we;
    assign io_adr    = r_io_adr;
    assign io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_mem_io_bus.sv
// Self-checking bench for mem_io_bus: RAM and peripheral models, expected-result scoreboard.
// Covers the IO_TIMEOUT_EN build as well as the default build.
module tb_mem_io_bus;

    localparam int NEVER   = 10000;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, busy, bus_err;
    logic        mem_en, mem_we;
    logic [15:0] mem_adr, mem_wdata, mem_rdata;
    logic [3:0]  io_req, io_ack;
    logic        io_we;
    logic [13:0] io_adr;
    logic [15:0] io_wdata;
    logic [63:0] io_rdata;

    always #5 clk = ~clk;

    mem_io_bus #(.DATA_W(16), .ADDR_W(16), .NUM_IO(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy(busy), .bus_err(bus_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .io_req(io_req), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] wd;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        logic [3:0]  req;
        int          mem_cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ram[256];
    logic [15:0] ref_mem[256];
    logic [15:0] ch_data[4];
    logic [15:0] wr_log[4];
    int          ack_dly[4];
    int          pcnt[4];
    logic [3:0]  stray;

    // Synchronous RAM (1-cycle read latency) and peripherals acking after ack_dly cycles.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_adr[7:0]] <= mem_wdata;
            mem_rdata <= ram[mem_adr[7:0]];
        end
        for (int c = 0; c < 4; c++) begin
            pcnt[c] <= (io_req[c] === 1'b1) ? pcnt[c] + 1 : 0;
            if (io_req[c] && io_ack[c] && io_we) wr_log[c] <= io_wdata;
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            io_rdata[c*16 +: 16] = ch_data[c];
            io_ack[c] = ((io_req[c] === 1'b1) && (pcnt[c] >= ack_dly[c])) || stray[c];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] adr, input logic [15:0] wd);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("idle_before_issue", busy, 0);
        cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_adr = 16'($urandom); cpu_wdata = 16'($urandom);
    endtask

    task automatic collect();
        exp_t e;
        int   t = 0;
        int   mem_hi = 0;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("io_req_onehot", io_req, e.req);
        if (e.req != 0) begin
            check("io_adr", io_adr, e.adr[13:0]);
            check("io_we", io_we, e.we);
            if (e.we) check("io_wdata", io_wdata, e.wd);
        end
        if (e.mem_cycles != 0) begin
            check("mem_adr", mem_adr, e.adr);
            check("mem_we", mem_we, e.we);
            if (e.we) check("mem_wdata", mem_wdata, e.wd);
        end
        while (!cpu_ack && t < e.lat + 20) begin
            if (mem_en) mem_hi++;
            @(posedge clk); #1; t++;
        end
        check("ack_latency", t, e.lat);
        check("cpu_rdata", cpu_rdata, e.rdata);
        check("bus_err", bus_err, e.err);
        check("mem_en_cycles", mem_hi, e.mem_cycles);
        @(posedge clk); #1;
        check("ack_one_cycle", cpu_ack, 0);
        check("busy_after_resp", busy, 0);
        check("rdata_hold", cpu_rdata, e.rdata);
    endtask

    task automatic run(input logic we, input logic [15:0] adr, input logic [15:0] wd, input int dly);
        exp_t e;
        e.we = we; e.adr = adr; e.wd = wd; e.rdata = '0; e.err = 1'b0;
        e.req = '0; e.mem_cycles = 0; e.lat = 0;
        if (adr[15:14] != 2'b11) begin
            e.lat = 2; e.mem_cycles = 1;
            if (we) ref_mem[adr[7:0]] = wd;
            else    e.rdata = ref_mem[adr[7:0]];
        end else if (adr[13:2] == 12'h000) begin
            ack_dly[adr[1:0]] = dly;
            e.req = 4'b0001 << adr[1:0];
            if (dly >= NEVER) begin
                e.lat = TIMEOUT + 1; e.err = 1'b1; e.rdata = 16'hFFFF;
            end else begin
                e.lat = dly + 1;
                e.rdata = we ? 16'h0000 : ch_data[adr[1:0]];
            end
        end
        sb.push_back(e);
        issue(we, adr, wd);
        collect();
        if (e.req != 0 && we && !e.err) check("io_write_seen", wr_log[adr[1:0]], wd);
    endtask

    initial begin
        int          kind, wait_cycles, acks;
        logic [1:0]  rch;
        logic [7:0]  ra;
        logic [15:0] rd, saved;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0; stray = '0;
        for (int c = 0; c < 4; c++) begin
            ch_data[c] = 16'h1000 * 16'(c + 1) + 16'(c);
            wr_log[c]  = '0;
            ack_dly[c] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'hA000 + 16'(i);
            ref_mem[i] = 16'hA000 + 16'(i);
        end
        ram[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_adr", mem_adr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_io_req", io_req, 0);
        check("rst_io_we", io_we, 0);
        check("rst_io_adr", io_adr, 0);
        check("rst_io_wdata", io_wdata, 0);
        rst = 1'b0;

        run(1'b0, 16'h0010, 16'h0000, 0);
        run(1'b1, 16'h0020, 16'h5A5A, 0);
        run(1'b0, 16'h0020, 16'h0000, 0);
        run(1'b1, 16'hC002, 16'h1234, 3);
        for (int c = 0; c < 4; c++) run(1'b0, 16'hC000 + 16'(c), 16'h0000, c);
        stray = 4'b1101;
        run(1'b0, 16'hC001, 16'h0000, 2);
        stray = 4'b0000;
        run(1'b0, 16'hBFFF, 16'h0000, 0);
        run(1'b0, 16'hC010, 16'h0000, 0);
        saved = wr_log[3];
        run(1'b1, 16'hFFF3, 16'hDEAD, 0);
        check("unmapped_write_dropped", wr_log[3], saved);

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            rch  = 2'($urandom_range(0, 3));
            ra   = 8'($urandom);
            rd   = 16'($urandom);
            case (kind)
                0: run(1'b0, {8'h00, ra}, 16'h0000, 0);
                1: run(1'b1, {8'h00, ra}, rd, 0);
                2: begin
                    ch_data[rch] = rd;
                    run(1'b0, {14'h3000, rch}, 16'h0000, int'($urandom_range(0, 4)));
                end
                default: run(1'b1, {14'h3000, rch}, rd, int'($urandom_range(0, 4)));
            endcase
        end

`ifdef IO_TIMEOUT_EN
        run(1'b0, 16'hC001, 16'h0000, NEVER);
        wait_cycles = 5;
`else
        wait_cycles = 100;
`endif
        ack_dly[1] = NEVER;
        issue(1'b0, 16'hC001, 16'h0000);
        acks = 0;
        repeat (wait_cycles) begin
            if (cpu_ack) acks++;
            @(posedge clk); #1;
        end
        check("stalled_busy", busy, 1);
        check("stalled_no_ack", acks, 0);
        check("stalled_io_req", io_req, 4'b0010);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_io_req", io_req, 0);
        check("midrst_cpu_ack", cpu_ack, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        ack_dly[1] = 0;
        run(1'b0, 16'h0010, 16'h0000, 0);
        run(1'b1, 16'hC001, 16'h7777, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
